line_mem_responder: RTL and testbench

Responder end of the 256-bit line-transfer handshake that the data cache drives toward main memory. It holds a 512-line × 256-bit backing store and accepts one request per transaction on `enable_i`/`write_i`/`addr_i`/`data_i`. After a fixed, parameterised latency it completes the request and pulses `ack_o`, returning read data on `data_o`. It sits below the dcache at the top level and is the synthesizable, latency-accurate memory model used in CPU-plus-cache simulation.

---
 rtl/mem_if_pkg.sv | 20 ++
 rtl/line_sram.sv | 44 ++++
 rtl/line_mem_responder.sv | 127 ++++++++++++
 tb/tb_line_mem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Types and constants shared by the dcache controller and the line memory
// responder: line geometry, transaction FSM states and line-index extraction.
package mem_if_pkg;

  localparam int unsigned MEM_LINE_BITS = 256;
  localparam int unsigned MEM_LINES     = 512;
  localparam int unsigned MEM_OFF_W     = 5;
  localparam int unsigned MEM_INDEX_W   = $clog2(MEM_LINES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } mem_state_e;

  function automatic logic [MEM_INDEX_W-1:0] line_index(input logic [31:0] addr);
    return addr[MEM_OFF_W +: MEM_INDEX_W];
  endfunction

endpackage

// File: rtl/line_sram.sv
// Single-port synchronous line array with registered read data.
// The array itself has no reset; only the read register is cleared.
module line_sram
  import mem_if_pkg::*;
#(
  parameter int unsigned LINES     = MEM_LINES,
  parameter int unsigned LINE_BITS = MEM_LINE_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [$clog2(LINES)-1:0] addr_i,
  input  logic [LINE_BITS-1:0]     wdata_i,
  output logic [LINE_BITS-1:0]     rdata_o
);

  logic [LINE_BITS-1:0] mem [LINES];
  logic [LINE_BITS-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem[addr_i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// Latency-accurate responder for the dcache line-transfer handshake: latches a
// request, counts LATENCY cycles, accesses the line array and pulses ack_o.
module line_mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned LINES     = MEM_LINES,
  parameter int unsigned LINE_BITS = MEM_LINE_BITS,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LATENCY   = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [LINE_BITS-1:0] data_i,
  input  logic                 enable_i,
  input  logic                 write_i,
  output logic                 ack_o,
  output logic [LINE_BITS-1:0] data_o,
  output logic                 busy_o,
  output logic                 proto_err_o
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic                 wr_q, wr_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 mem_we, mem_re, violation;
  logic [IDX_W-1:0]     line_idx;

  assign line_idx = addr_q[MEM_OFF_W +: IDX_W];

  // The array is accessed on the WAIT->ACK edge, so LATENCY=1 also passes
  // through one WAIT cycle (counter already 0): ack lands after edge
  // E0+LATENCY and the back-to-back period stays LATENCY+2.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    violation = !enable_i || (addr_i != addr_q) || (write_i != wr_q) ||
                (wr_q && (data_i != wdata_q));
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          addr_d  = addr_i;
          wr_d    = write_i;
          wdata_d = data_i;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (violation) begin
          err_d = 1'b1;
        end
        if (cnt_q == '0) begin
          mem_we  = wr_q;
          mem_re  = !wr_q;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK: begin
        if (violation) begin
          err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ack_d  = (state_d == ST_ACK);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  line_sram #(
    .LINES     (LINES),
    .LINE_BITS (LINE_BITS)
  ) u_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (line_idx),
    .wdata_i (wdata_q),
    .rdata_o (data_o)
  );

  assign ack_o       = ack_q;
  assign busy_o      = busy_q;
  assign proto_err_o = err_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: drivers push expected read data,
// negedge monitors pop and compare whenever ack_o pulses.
module tb_line_mem_responder;

  localparam int unsigned LB = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   addr = '0, addr1 = '0;
  logic [LB-1:0] din = '0, din1 = '0;
  logic          en = 1'b0, wr = 1'b0, en1 = 1'b0, wr1 = 1'b0;
  logic          ack, busy, perr, ack1, busy1, perr1;
  logic [LB-1:0] dout, dout1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    string         name;
    logic [LB-1:0] data;
  } exp_t;

  exp_t          sb[$];
  exp_t          sb1[$];
  logic [LB-1:0] last_rd = '0;

  localparam logic [LB-1:0] L0   = 256'h5;
  localparam logic [LB-1:0] L1   = {8{32'h1111_0001}};
  localparam logic [LB-1:0] L3   = {8{32'h3333_0003}};
  localparam logic [LB-1:0] L32  = {8{32'hDEAD_0020}};
  localparam logic [LB-1:0] A5   = {32{8'hA5}};
  localparam logic [LB-1:0] B0   = {8{32'hB000_0000}};
  localparam logic [LB-1:0] B1   = {8{32'hB111_1111}};
  localparam logic [LB-1:0] B2   = {8{32'hB222_2222}};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  line_mem_responder #(.LATENCY(10)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(din), .enable_i(en),
    .write_i(wr), .ack_o(ack), .data_o(dout), .busy_o(busy), .proto_err_o(perr)
  );

  line_mem_responder #(.LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr1), .data_i(din1), .enable_i(en1),
    .write_i(wr1), .ack_o(ack1), .data_o(dout1), .busy_o(busy1), .proto_err_o(perr1)
  );

  task automatic check(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack) begin
      if (sb.size() == 0) check("dut_ack_without_request", LB'(ack), '0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, dout, e.data);
      end
    end
    if (ack1) begin
      if (sb1.size() == 0) check("dut1_ack_without_request", LB'(ack1), '0);
      else begin
        exp_t e1;
        e1 = sb1.pop_front();
        check(e1.name, dout1, e1.data);
      end
    end
  end

  // glitch: negedge count at which enable is dropped for one cycle (0 = none)
  // rst_at: negedge count at which reset is asserted (0 = none)
  task automatic txn(input bit w, input logic [31:0] a, input logic [LB-1:0] d,
                     input logic [LB-1:0] rexp, input string nm,
                     input int glitch, input int rst_at);
    int c;
    bit seen, busy_ok;
    if (rst_at == 0) begin
      if (!w) last_rd = rexp;
      sb.push_back('{nm, last_rd});
    end
    @(negedge clk);
    check({nm, "_idle_before"}, LB'(busy), '0);
    en = 1'b1; wr = w; addr = a; din = d;
    @(posedge clk);
    c = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && c < 50) begin
      @(negedge clk);
      c++;
      if (rst_at != 0 && c == rst_at) begin
        rst = 1'b1;
        #1;
        check({nm, "_busy_at_reset"}, LB'(busy), '0);
        check({nm, "_ack_at_reset"}, LB'(ack), '0);
        check({nm, "_data_at_reset"}, dout, '0);
        last_rd = '0;
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        return;
      end
      if (glitch != 0 && c == glitch) begin
        check({nm, "_perr_before"}, LB'(perr), '0);
        en = 1'b0;
      end
      if (glitch != 0 && c == glitch + 1) begin
        check({nm, "_perr_after"}, LB'(perr), LB'(1));
        en = 1'b1;
      end
      if (!busy) busy_ok = 1'b0;
      if (ack) seen = 1'b1;
    end
    check({nm, "_latency"}, LB'(c), LB'(11));
    check({nm, "_busy_held"}, LB'(busy_ok), LB'(1));
  endtask

  task automatic go_idle(input int n);
    @(negedge clk);
    en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int nack;
    int c;
    int last_ack;
    logic [LB-1:0] d1 [3];
    d1[0] = B0; d1[1] = B1; d1[2] = B2;

    dut.u_sram.mem[0]  = L0;
    dut.u_sram.mem[1]  = L1;
    dut.u_sram.mem[3]  = L3;
    dut.u_sram.mem[32] = L32;
    dut1.u_sram.mem[0] = B0;
    dut1.u_sram.mem[1] = B1;
    dut1.u_sram.mem[2] = B2;

    repeat (3) @(negedge clk);
    check("reset_ack", LB'(ack), '0);
    check("reset_busy", LB'(busy), '0);
    check("reset_perr", LB'(perr), '0);
    check("reset_data", dout, '0);
    rst = 1'b0;

    txn(1'b0, 32'h0000, '0, L0, "t1_read_line0", 0, 0);
    go_idle(1);

    txn(1'b1, 32'h0400, A5, '0, "t2_write_0400", 0, 0);
    txn(1'b0, 32'h0400, '0, A5, "t2_read_0400", 0, 0);
    go_idle(1);
    check("t2_line32_updated", dut.u_sram.mem[32], A5);
    check("t2_line0_unchanged", dut.u_sram.mem[0], L0);

    txn(1'b0, 32'h4020, '0, L1, "t3_read_4020", 0, 0);
    txn(1'b0, 32'h003F, '0, L1, "t3_read_003f", 0, 0);
    go_idle(1);
    check("t3_perr_clear", LB'(perr), '0);

    txn(1'b1, 32'h0060, '1, '0, "t4_write_rst", 0, 4);
    nack = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ack) nack++;
    end
    check("t4_no_ack", LB'(nack), '0);
    check("t4_line3_kept", dut.u_sram.mem[3], L3);
    txn(1'b0, 32'h0060, '0, L3, "t4_read_back", 0, 0);
    go_idle(1);

    txn(1'b0, 32'h0020, '0, L1, "t5_glitch_read", 3, 0);
    go_idle(2);
    check("t5_perr_sticky", LB'(perr), LB'(1));
    txn(1'b0, 32'h0000, '0, L0, "t5_read_after", 0, 0);
    go_idle(1);
    check("t5_perr_still", LB'(perr), LB'(1));

    @(negedge clk);
    en1 = 1'b1; addr1 = 32'h0;
    last_ack = 0;
    for (int k = 0; k < 3; k++) begin
      sb1.push_back('{$sformatf("t6_read_%0d", k), d1[k]});
      c = 0;
      while (!ack1 && c < 20) begin
        @(negedge clk);
        c++;
      end
      if (k == 0) check("t6_first_latency", LB'(c), LB'(2));
      else check($sformatf("t6_period_%0d", k), LB'(cyc - last_ack), LB'(3));
      last_ack = cyc;
      @(negedge clk);
      if (k < 2) addr1 = 32'((k + 1) * 32);
    end
    en1 = 1'b0;
    nack = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack1) nack++;
    end
    check("t6_no_extra_ack", LB'(nack), '0);
    check("t6_perr_clear", LB'(perr1), '0);

    check("sb_drained", LB'(sb.size() + sb1.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
